uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning TX byte FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter DATA_ADDR, default 32'h00004000, meaning UART TX data register address.
REQ-003 SHALL have parameter STATUS_ADDR, default 32'h00004004, meaning UART status register address.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port addr  in  32  CPU data-bus address.
REQ-007 SHALL have port data_from_cpu  in  32  CPU write data; bits [7:0] are the byte.
REQ-008 SHALL have port mem_write_cpu  in  1  CPU store strobe, one cycle per store.
REQ-009 SHALL have port mem_read_cpu  in  1  CPU load strobe.
REQ-010 SHALL have port status_to_cpu  out  32  status word toward the MMU read mux.
REQ-011 SHALL have port uart_busy  in  1  transmitter busy from the UART TX core.
REQ-012 SHALL have port uart_start  out  1  one-cycle start pulse to the UART TX core.
REQ-013 SHALL have port uart_data  out  8  byte to transmit, valid while uart_start is high.

Function
REQ-014 Push: SHALL push data_from_cpu[7:0] at an edge where mem_write_cpu=1 and addr==DATA_ADDR, if count<FIFO_DEPTH or a pop occurs on the same edge.
REQ-015 Full drop: a push attempt with count==FIFO_DEPTH and no same-edge pop SHALL leave the FIFO unchanged and set sticky overflow.
REQ-016 Status: status_to_cpu SHALL be combinational: {count in [15:8], 4'b0, overflow [3], fsm_active [2], empty [1], full [0]} when mem_read_cpu=1 and addr==STATUS_ADDR, else 32'b0.
REQ-017 Overflow clear: a status read SHALL clear overflow at that edge, unless an overflowing push occurs on the same edge, in which case overflow stays 1.
REQ-018 FSM states: IDLE, WAIT_BUSY, WAIT_DONE; fsm_active=1 outside IDLE.
REQ-019 IDLE: if FIFO non-empty and uart_busy=0, SHALL register uart_start=1, uart_data=head byte, pop, and go to WAIT_BUSY; otherwise stay.
REQ-020 uart_start SHALL be high for exactly one cycle per popped byte; uart_data SHALL hold its value until the next start.
REQ-021 WAIT_BUSY: SHALL go to WAIT_DONE on uart_busy=1; after 4 cycles without busy, SHALL return to IDLE (byte counted as sent).
REQ-022 WAIT_DONE: SHALL return to IDLE on uart_busy=0.
REQ-023 Latency: a byte pushed into an empty FIFO at edge k, with uart_busy=0 and FSM in IDLE, SHALL produce uart_start high in the cycle after edge k+1.
REQ-024 Ordering: bytes SHALL be transmitted in strict push order; FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width SHALL be clog2(FIFO_DEPTH)+1.
REQ-025 Writes to any other address, and reads of DATA_ADDR, SHALL have no effect.

Reset
REQ-026 With rst_n=0 at an edge, the block SHALL set state=IDLE, count=0, pointers=0, overflow=0, uart_start=0, uart_data=8'h00.
REQ-027 Reset mid-transfer SHALL discard FIFO contents and the pending byte; no uart_start SHALL be issued in the cycle following the reset edge.

Structure
REQ-028 DATA_ADDR/STATUS_ADDR defaults, the RAM window (32'h00002000..32'h00003FFF), status bit positions and the FSM state encoding SHALL live in shared package soc_map_pkg.
REQ-029 FIFO storage SHALL be one sub-module, sync_fifo (parameterised width/depth, push/pop/full/empty/count); the FSM and decode stay in uart_tx_ctrl.

Verification
REQ-030 Reset, then a store of 32'h00000041 to 32'h00004000 with uart_busy=0 -> uart_start pulses once, 2 edges later, with uart_data=8'h41; then empty=1.
REQ-031 Hold uart_busy=1, store 9 bytes 8'h01..8'h09 -> count=8, full=1, overflow=1; release busy -> 8'h01..8'h08 transmitted in order, 8'h09 never.
REQ-032 Status read with overflow=1 -> status_to_cpu bit3=1 that cycle and 0 on the next read; a read of any other address returns 32'b0.
REQ-033 Pop a byte while uart_busy never rises -> FSM returns to IDLE 4 cycles later; the next byte then starts.
REQ-034 With FIFO full, a push on the same edge the FSM pops -> push accepted, count stays 8, overflow stays 0.
REQ-035 Assert rst_n=0 during WAIT_DONE with 3 bytes queued -> count=0, uart_start=0, no further starts after rst_n returns to 1.

Source files
------------

// File: rtl/soc_map_pkg.sv
// Shared SoC memory map and UART TX controller definitions.
// Holds peripheral addresses, status-word layout and the TX FSM encoding.
package soc_map_pkg;

    localparam logic [31:0] UART_DATA_ADDR   = 32'h0000_4000;
    localparam logic [31:0] UART_STATUS_ADDR = 32'h0000_4004;
    localparam logic [31:0] RAM_BASE_ADDR    = 32'h0000_2000;
    localparam logic [31:0] RAM_LAST_ADDR    = 32'h0000_3FFF;

    localparam int STAT_FULL_BIT   = 0;
    localparam int STAT_EMPTY_BIT  = 1;
    localparam int STAT_ACTIVE_BIT = 2;
    localparam int STAT_OVF_BIT    = 3;
    localparam int STAT_COUNT_LSB  = 8;

    // Idle cycles the controller waits for the core to raise busy before giving up on it
    localparam int TX_ACK_TIMEOUT = 4;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_BUSY = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_e;

    function automatic logic [31:0] uart_status_word(
        input logic [7:0] count,
        input logic       ovf,
        input logic       active,
        input logic       empty,
        input logic       full
    );
        logic [31:0] word;
        word                         = 32'h0000_0000;
        word[STAT_COUNT_LSB +: 8]    = count;
        word[STAT_OVF_BIT]           = ovf;
        word[STAT_ACTIVE_BIT]        = active;
        word[STAT_EMPTY_BIT]         = empty;
        word[STAT_FULL_BIT]          = full;
        return word;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage array; no reset so it can map onto plain RAM
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// CPU-facing UART transmit controller: address decode, byte FIFO, status word,
// and a handshake FSM that feeds one byte at a time to the UART TX core.
module uart_tx_ctrl
    import soc_map_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] DATA_ADDR   = UART_DATA_ADDR,
    parameter logic [31:0] STATUS_ADDR = UART_STATUS_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] data_from_cpu,
    input  logic        mem_write_cpu,
    input  logic        mem_read_cpu,
    output logic [31:0] status_to_cpu,
    input  logic        uart_busy,
    output logic        uart_start,
    output logic [7:0]  uart_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            push_req_s;
    logic            status_rd_s;
    logic            overflow_event_s;
    logic            pop_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [CW-1:0]   fifo_count_s;
    logic [7:0]      head_s;
    logic            unused_s;

    tx_state_e       state_r;
    tx_state_e       state_nx_s;
    logic [2:0]      wait_cnt_r;
    logic [2:0]      wait_cnt_nx_s;
    logic            overflow_r;
    logic            uart_start_r;
    logic [7:0]      uart_data_r;

    assign push_req_s       = mem_write_cpu && (addr == DATA_ADDR);
    assign status_rd_s      = mem_read_cpu && (addr == STATUS_ADDR);
    assign overflow_event_s = push_req_s && fifo_full_s && !pop_s;
    assign unused_s         = ^data_from_cpu[31:8];

    assign status_to_cpu = status_rd_s
        ? uart_status_word(8'(fifo_count_s), overflow_r, (state_r != TX_IDLE),
                           fifo_empty_s, fifo_full_s)
        : 32'h0000_0000;

    assign uart_start = uart_start_r;
    assign uart_data  = uart_data_r;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req_s),
        .pop   (pop_s),
        .wdata (data_from_cpu[7:0]),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Handshake FSM next-state and pop decision
    always_comb begin
        state_nx_s    = state_r;
        wait_cnt_nx_s = wait_cnt_r;
        pop_s         = 1'b0;
        case (state_r)
            TX_IDLE: begin
                if (!fifo_empty_s && !uart_busy) begin
                    pop_s         = 1'b1;
                    state_nx_s    = TX_WAIT_BUSY;
                    wait_cnt_nx_s = 3'd0;
                end else begin
                    state_nx_s    = TX_IDLE;
                end
            end
            TX_WAIT_BUSY: begin
                if (uart_busy) begin
                    state_nx_s    = TX_WAIT_DONE;
                end else if (wait_cnt_r == 3'(TX_ACK_TIMEOUT - 1)) begin
                    // Core never acknowledged; treat the byte as sent
                    state_nx_s    = TX_IDLE;
                end else begin
                    wait_cnt_nx_s = wait_cnt_r + 3'd1;
                end
            end
            TX_WAIT_DONE: begin
                if (!uart_busy) begin
                    state_nx_s = TX_IDLE;
                end else begin
                    state_nx_s = TX_WAIT_DONE;
                end
            end
            default: begin
                state_nx_s = TX_IDLE;
            end
        endcase
    end

    // FSM state, sticky overflow and registered core-side outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= TX_IDLE;
            wait_cnt_r   <= 3'd0;
            overflow_r   <= 1'b0;
            uart_start_r <= 1'b0;
            uart_data_r  <= 8'h00;
        end else begin
            state_r      <= state_nx_s;
            wait_cnt_r   <= wait_cnt_nx_s;
            uart_start_r <= pop_s;
            if (pop_s) begin
                uart_data_r <= head_s;
            end
            if (overflow_event_s) begin
                overflow_r <= 1'b1;
            end else if (status_rd_s) begin
                overflow_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed vector table, corner-case
// sequences, and randomized traffic against a transaction-level model.
module tb_uart_tx_ctrl;

    localparam int          DEPTH = 8;
    localparam logic [31:0] DATA  = 32'h0000_4000;
    localparam logic [31:0] STAT  = 32'h0000_4004;
    localparam logic [31:0] OTHER = 32'h0000_4008;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] data_from_cpu;
    logic        mem_write_cpu;
    logic        mem_read_cpu;
    logic [31:0] status_to_cpu;
    logic        uart_busy;
    logic        uart_start;
    logic [7:0]  uart_data;

    uart_tx_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr          (addr),
        .data_from_cpu (data_from_cpu),
        .mem_write_cpu (mem_write_cpu),
        .mem_read_cpu  (mem_read_cpu),
        .status_to_cpu (status_to_cpu),
        .uart_busy     (uart_busy),
        .uart_start    (uart_start),
        .uart_data     (uart_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: queue of pending bytes plus a "byte in flight" view of the core
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_active;
    bit         m_saw_busy;
    int         m_quiet;
    logic       m_start;
    logic [7:0] m_data;

    logic [31:0] status_obs;
    logic        start_obs;
    logic [7:0]  data_obs;
    logic [7:0]  sent[$];

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] a;
        logic [31:0] d;
        logic        busy;
        logic [31:0] exp_status;
        logic        exp_start;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_status(input logic rd, input logic [31:0] a);
        logic [31:0] w;
        w = 32'h0;
        if (rd && a == STAT) begin
            w = (mq.size() << 8) | (int'(m_ovf) << 3) | (int'(m_active) << 2)
              | (int'(mq.size() == 0) << 1) | int'(mq.size() == DEPTH);
        end
        return w;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ovf      = 1'b0;
        m_active   = 1'b0;
        m_saw_busy = 1'b0;
        m_quiet    = 0;
        m_start    = 1'b0;
        m_data     = 8'h00;
    endfunction

    function automatic void model_edge(input logic wr, input logic rd, input logic [31:0] a,
                                       input logic [31:0] d, input logic b);
        bit send;
        bit preq;
        bit srd;
        bit ovf_ev;
        send   = !m_active && (mq.size() > 0) && !b;
        preq   = wr && (a == DATA);
        srd    = rd && (a == STAT);
        ovf_ev = preq && (mq.size() == DEPTH) && !send;
        m_start = send;
        if (send) begin
            m_data     = mq.pop_front();
            m_active   = 1'b1;
            m_saw_busy = 1'b0;
            m_quiet    = 0;
        end else if (m_active) begin
            if (!m_saw_busy) begin
                if (b) m_saw_busy = 1'b1;
                else begin
                    m_quiet++;
                    if (m_quiet == 4) m_active = 1'b0;
                end
            end else if (!b) begin
                m_active = 1'b0;
            end
        end
        if (preq && !ovf_ev) mq.push_back(d[7:0]);
        if (ovf_ev) m_ovf = 1'b1;
        else if (srd) m_ovf = 1'b0;
    endfunction

    task automatic step(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input logic b, input bit vs_model);
        mem_write_cpu = wr;
        mem_read_cpu  = rd;
        addr          = a;
        data_from_cpu = d;
        uart_busy     = b;
        #3;
        status_obs = status_to_cpu;
        if (vs_model) check("status", status_obs, model_status(rd, a));
        @(posedge clk);
        model_edge(wr, rd, a, d, b);
        #1;
        start_obs = uart_start;
        data_obs  = uart_data;
        if (start_obs === 1'b1) sent.push_back(data_obs);
        if (vs_model) begin
            check("uart_start", 32'(start_obs), 32'(m_start));
            check("uart_data", 32'(data_obs), 32'(m_data));
        end
    endtask

    task automatic do_reset(input logic b);
        rst_n         = 1'b0;
        mem_write_cpu = 1'b0;
        mem_read_cpu  = 1'b0;
        addr          = 32'h0;
        data_from_cpu = 32'h0;
        uart_busy     = b;
        @(posedge clk);
        #1;
        model_reset();
        check("rst_start", 32'(uart_start), 32'h0);
        check("rst_data", 32'(uart_data), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        int gap;
        bit found;

        vecs[0]  = '{1'b0, 1'b1, STAT,  32'h0,  1'b0, 32'h0000_0002, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, DATA,  32'h41, 1'b0, 32'h0000_0000, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, STAT,  32'h0,  1'b0, 32'h0000_0100, 1'b1, 8'h41};
        vecs[3]  = '{1'b0, 1'b1, STAT,  32'h0,  1'b0, 32'h0000_0006, 1'b0, 8'h41};
        vecs[4]  = '{1'b0, 1'b1, STAT,  32'h0,  1'b1, 32'h0000_0006, 1'b0, 8'h41};
        vecs[5]  = '{1'b0, 1'b1, STAT,  32'h0,  1'b0, 32'h0000_0006, 1'b0, 8'h41};
        vecs[6]  = '{1'b0, 1'b1, STAT,  32'h0,  1'b0, 32'h0000_0002, 1'b0, 8'h41};
        vecs[7]  = '{1'b0, 1'b1, DATA,  32'h0,  1'b0, 32'h0000_0000, 1'b0, 8'h41};
        vecs[8]  = '{1'b1, 1'b0, OTHER, 32'h55, 1'b0, 32'h0000_0000, 1'b0, 8'h41};
        vecs[9]  = '{1'b0, 1'b1, STAT,  32'h0,  1'b0, 32'h0000_0002, 1'b0, 8'h41};
        vecs[10] = '{1'b1, 1'b1, DATA,  32'h7E, 1'b0, 32'h0000_0000, 1'b0, 8'h41};
        vecs[11] = '{1'b0, 1'b1, STAT,  32'h0,  1'b0, 32'h0000_0100, 1'b1, 8'h7E};

        do_reset(1'b0);
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].d, vecs[i].busy, 1'b0);
            check($sformatf("vec%0d_status", i), status_obs, vecs[i].exp_status);
            check($sformatf("vec%0d_start", i), 32'(start_obs), 32'(vecs[i].exp_start));
            check($sformatf("vec%0d_data", i), 32'(data_obs), 32'(vecs[i].exp_data));
        end

        // Overflow while the core is held busy, then drain in order
        do_reset(1'b1);
        for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, DATA, 32'(i), 1'b1, 1'b1);
        step(1'b0, 1'b1, STAT, 32'h0, 1'b1, 1'b1);
        check("ovf_status", status_obs, 32'h0000_0809);
        step(1'b0, 1'b1, STAT, 32'h0, 1'b1, 1'b1);
        check("ovf_cleared", status_obs, 32'h0000_0801);
        step(1'b0, 1'b1, OTHER, 32'h0, 1'b1, 1'b1);
        check("other_read", status_obs, 32'h0);
        sent.delete();
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, OTHER, 32'h0, 1'b0, 1'b1);
        check("drain_count", 32'(sent.size()), 32'd8);
        for (int i = 0; i < sent.size() && i < 8; i++)
            check($sformatf("drain_byte%0d", i), 32'(sent[i]), 32'(i + 1));

        // Core never raises busy: next byte starts after the timeout
        do_reset(1'b0);
        step(1'b1, 1'b0, DATA, 32'hA1, 1'b0, 1'b1);
        step(1'b1, 1'b0, DATA, 32'hA2, 1'b0, 1'b1);
        check("noack_first", 32'(data_obs), 32'hA1);
        gap   = 0;
        found = 1'b0;
        for (int i = 1; i <= 12 && !found; i++) begin
            step(1'b0, 1'b1, STAT, 32'h0, 1'b0, 1'b1);
            if (start_obs === 1'b1) begin
                found = 1'b1;
                gap   = i;
            end
        end
        check("noack_gap", 32'(gap), 32'd5);
        check("noack_second", 32'(data_obs), 32'hA2);

        // Push into a full FIFO on the same edge as a pop
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DATA, 32'(8'h10 + i), 1'b1, 1'b1);
        step(1'b1, 1'b0, DATA, 32'h99, 1'b0, 1'b1);
        check("fullpop_start", 32'(start_obs), 32'h1);
        step(1'b0, 1'b1, STAT, 32'h0, 1'b1, 1'b1);
        check("fullpop_status", status_obs, 32'h0000_0805);

        // Reset while waiting for the core with bytes queued
        do_reset(1'b0);
        step(1'b1, 1'b0, DATA, 32'hB1, 1'b0, 1'b1);
        step(1'b1, 1'b0, DATA, 32'hB2, 1'b0, 1'b1);
        step(1'b1, 1'b0, DATA, 32'hB3, 1'b1, 1'b1);
        step(1'b1, 1'b0, DATA, 32'hB4, 1'b1, 1'b1);
        step(1'b0, 1'b1, STAT, 32'h0, 1'b1, 1'b1);
        check("midrst_before", status_obs, 32'h0000_0304);
        do_reset(1'b1);
        sent.delete();
        step(1'b0, 1'b1, STAT, 32'h0, 1'b0, 1'b1);
        check("midrst_after", status_obs, 32'h0000_0002);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, OTHER, 32'h0, 1'b0, 1'b1);
        check("midrst_nostart", 32'(sent.size()), 32'd0);

        // Randomized traffic against the model
        begin
            logic rb;
            rb = 1'b0;
            for (int i = 0; i < 600; i++) begin
                int unsigned sel;
                logic [31:0] ra;
                if ($urandom_range(99) < 25) rb = ~rb;
                if ($urandom_range(199) == 0) begin
                    do_reset(rb);
                end else begin
                    sel = $urandom_range(3);
                    case (sel)
                        0, 1:    ra = DATA;
                        2:       ra = STAT;
                        default: ra = ($urandom_range(1) == 0) ? OTHER : $urandom();
                    endcase
                    step(logic'($urandom_range(99) < 45), logic'($urandom_range(99) < 40),
                         ra, $urandom(), rb, 1'b1);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
